// File: rtl/cpu_io_if.sv
// cpu_io_if: CPU-side memory bus between the stack CPU core and cpu_io.
// The core drives word address, store data and write strobe, and reads
// back combinational read data in the same cycle.
interface cpu_io_if;
  logic [15:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic        cpu_wr;
  logic [15:0] cpu_rdata;

  modport master (
    output cpu_address,
    output cpu_wdata,
    output cpu_wr,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_address,
    input  cpu_wdata,
    input  cpu_wr,
    output cpu_rdata
  );
endinterface

// File: rtl/cpu_io.sv
// cpu_io: memory / I-O bus slave for the stack CPU.
// The low address region passes through to an asynchronous-read RAM. The
// top 256 words (IO_BASE) are a register page holding the LED register, the
// UART transmit FIFO, the status register and a free-running cycle counter.
// Reads are zero latency; writes commit on the clock edge where cpu_wr is high.
// Optional feature macro: CPU_IO_UART_EN. When defined, the transmit FIFO,
// 8N1 serializer and overflow flag are built; when undefined, uart_tx is held
// high, TXDATA writes are ignored and STATUS reads as "FIFO empty" only.
module cpu_io #(
  parameter logic [14:0] IO_BASE    = 15'h7F00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          BAUD_DIV   = 434
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_io_if.slave       cpu,
  output logic [14:0]   ram_addr,
  output logic [15:0]   ram_wdata,
  output logic          ram_we,
  input  logic [15:0]   ram_rdata,
  output logic [7:0]    leds,
  output logic          uart_tx
);

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_TXDATA = 8'h01;
  localparam logic [7:0] OFF_STATUS = 8'h02;
  localparam logic [7:0] OFF_CYCLES = 8'h03;

  logic        io_sel;
  logic [7:0]  io_off;
  logic        led_we;
  logic        cyc_we;
  logic [7:0]  leds_q;
  logic [15:0] cycles_q;
  logic [15:0] cycles_d;
  logic [15:0] status_word;
  logic [15:0] rd_mux;
  logic        unused_addr_msb;

  // Bit 15 of the CPU address is always driven 0 by the core.
  assign unused_addr_msb = cpu.cpu_address[15];

  assign io_sel    = (cpu.cpu_address[14:8] == IO_BASE[14:8]);
  assign io_off    = cpu.cpu_address[7:0];

  assign ram_addr  = cpu.cpu_address[14:0];
  assign ram_wdata = cpu.cpu_wdata;
  assign ram_we    = cpu.cpu_wr & ~io_sel;

  assign led_we    = cpu.cpu_wr & io_sel & (io_off == OFF_LED);
  assign cyc_we    = cpu.cpu_wr & io_sel & (io_off == OFF_CYCLES);

  assign leds      = leds_q;

  // LED register keeps the low byte of every write to offset 0x00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= 8'h00;
    end else if (led_we) begin
      leds_q <= cpu.cpu_wdata[7:0];
    end
  end

  // A CPU write loads the counter; otherwise it free-runs and wraps.
  always_comb begin
    cycles_d = cycles_q + 16'd1;
    if (cyc_we) begin
      cycles_d = cpu.cpu_wdata;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= 16'h0000;
    end else begin
      cycles_q <= cycles_d;
    end
  end

`ifdef CPU_IO_UART_EN

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic          fifo_pop;
  logic          tx_we;
  logic          stat_we;
  logic          push_ok;
  logic          ovf_q;
  logic          ovf_d;
  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          baud_done;
  logic          tx_busy;

  assign tx_we      = cpu.cpu_wr & io_sel & (io_off == OFF_TXDATA);
  assign stat_we    = cpu.cpu_wr & io_sel & (io_off == OFF_STATUS);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

  assign baud_done  = (baud_q == BAUD_LAST);
  // The serializer takes a byte when idle, or at the end of a stop bit so
  // back-to-back frames leave no gap.
  assign fifo_pop   = !fifo_empty &&
                      ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));
  // A pop in the same cycle frees a slot, so a push while full still lands.
  assign push_ok    = tx_we && (!fifo_full || fifo_pop);

  assign tx_busy    = (state_q != S_IDLE);
  assign status_word = {12'h000, ovf_q, tx_busy, fifo_empty, fifo_full};
  assign uart_tx    = tx_q;

  // FIFO storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= cpu.cpu_wdata[7:0];
    end
  end

  // FIFO pointers; reset discards any queued bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Sticky overflow: a dropped push sets it, writing STATUS bit3 clears it;
  // a drop in the same cycle as the clear wins so it is never lost.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_we && cpu.cpu_wdata[3]) begin
      ovf_d = 1'b0;
    end
    if (tx_we && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // 8N1 serializer with registered line output; the baud counter restarts on
  // every state entry so each bit lasts exactly BAUD_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_head;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_head;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`else

  // Without the UART the FIFO always looks empty and the line stays idle.
  assign status_word = 16'h0002;
  assign uart_tx     = 1'b1;

`endif

  // Zero-latency read path: RAM outside the I/O page, register file inside.
  always_comb begin
    rd_mux = ram_rdata;
    if (io_sel) begin
      case (io_off)
        OFF_LED:    rd_mux = {8'h00, leds_q};
        OFF_STATUS: rd_mux = status_word;
        OFF_CYCLES: rd_mux = cycles_q;
        default:    rd_mux = 16'h0000;
      endcase
    end
  end

  assign cpu.cpu_rdata = rd_mux;

endmodule

// File: tb/tb_cpu_io.sv
// tb_cpu_io: directed bench for cpu_io with a byte scoreboard on uart_tx.
// Expected UART bytes are queued when written to TXDATA and popped by a
// line monitor that decodes each frame; register reads are checked inline.
module tb_cpu_io;

  localparam logic [14:0] IO_BASE    = 15'h7F00;
  localparam int          FIFO_DEPTH = 8;
  localparam int          BAUD_DIV   = 4;

  localparam logic [15:0] A_LED  = 16'h7F00;
  localparam logic [15:0] A_TX   = 16'h7F01;
  localparam logic [15:0] A_STAT = 16'h7F02;
  localparam logic [15:0] A_CYC  = 16'h7F03;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [7:0]  leds;
  logic        uart_tx;

  logic [15:0] ramModel [256];
  logic [7:0]  expQ[$];
  int          startQ[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          wCyc;

  cpu_io_if bus ();

  cpu_io #(
    .IO_BASE    (IO_BASE),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .leds      (leds),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Small asynchronous-read RAM model indexed by the low address byte.
  always @(posedge clk) begin
    if (ram_we) ramModel[ram_addr[7:0]] <= ram_wdata;
  end
  assign ram_rdata = ramModel[ram_addr[7:0]];

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic w);
    bus.cpu_address = a;
    bus.cpu_wdata   = d;
    bus.cpu_wr      = w;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeBus(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(a, d, 1'b1);
    stepCycle();
    applyStimulus(a, 16'h0000, 1'b0);
  endtask

  task automatic readCheck(input string tag, input logic [15:0] a, input logic [15:0] exp);
    applyStimulus(a, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput(tag, bus.cpu_rdata, exp);
    stepCycle();
  endtask

  // Line monitor: samples mid-bit on falling clock edges and scores each byte.
  initial begin : uartMonitor
    int          mcnt;
    bit          active;
    logic [7:0]  sh;
    mcnt   = 0;
    active = 1'b0;
    sh     = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (uart_tx == 1'b0) begin
          active = 1'b1;
          mcnt   = 0;
          startQ.push_back(cyc);
        end
      end else begin
        mcnt++;
      end
      if (active) begin
        if (mcnt == 2) begin
          checkOutput("start_bit", 16'(uart_tx), 16'h0000);
        end else if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2) begin
          sh = {uart_tx, sh[7:1]};
        end else if (mcnt == 38) begin
          checkOutput("stop_bit", 16'(uart_tx), 16'h0001);
          if (expQ.size() == 0) begin
            compared++;
            assert (expQ.size() != 0) else begin
              mismatched++;
              $error("[TB] FAIL frame_unexpected: observed byte 0x%02h expected no frame", sh);
            end
          end else begin
            checkOutput("tx_byte", {8'h00, sh}, {8'h00, expQ.pop_front()});
          end
        end
        if (mcnt == 39) active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    for (int i = 0; i < 256; i++) ramModel[i] = 16'h0000;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #2;
    checkOutput("reset_uart_tx", 16'(uart_tx), 16'h0001);
    checkOutput("reset_leds", 16'(leds), 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] reset values");
    readCheck("cycles_r0", A_CYC, 16'h0000);
    readCheck("cycles_r1", A_CYC, 16'h0001);
    readCheck("cycles_r2", A_CYC, 16'h0002);
    readCheck("led_reset", A_LED, 16'h0000);
    readCheck("txdata_read", A_TX, 16'h0000);
    readCheck("status_reset", A_STAT, 16'h0002);

    $display("[TB] RAM pass-through and LED");
    applyStimulus(16'h0010, 16'h1234, 1'b1);
    @(negedge clk);
    checkOutput("ram_we_low_region", 16'(ram_we), 16'h0001);
    checkOutput("ram_addr", 16'(ram_addr), 16'h0010);
    checkOutput("ram_wdata", ram_wdata, 16'h1234);
    stepCycle();
    readCheck("ram_read_0010", 16'h0010, 16'h1234);
    applyStimulus(16'h7EFF, 16'hCAFE, 1'b1);
    @(negedge clk);
    checkOutput("ram_we_below_page", 16'(ram_we), 16'h0001);
    stepCycle();
    readCheck("ram_read_7EFF", 16'h7EFF, 16'hCAFE);
    applyStimulus(A_LED, 16'h00A5, 1'b1);
    @(negedge clk);
    checkOutput("ram_we_io_page", 16'(ram_we), 16'h0000);
    stepCycle();
    applyStimulus(A_LED, 16'h0000, 1'b0);
    checkOutput("leds_a5", 16'(leds), 16'h00A5);
    readCheck("led_read_a5", A_LED, 16'h00A5);
    readCheck("ram_untouched_by_io", 16'h0000, 16'h0000);
    writeBus(A_LED, 16'h3C5A);
    readCheck("led_low_byte_only", A_LED, 16'h005A);
    writeBus(16'h7F80, 16'h00FF);
    readCheck("unmapped_reads_zero", 16'h7F80, 16'h0000);
    readCheck("led_unchanged", A_LED, 16'h005A);

    $display("[TB] CYCLES load and wrap");
    writeBus(A_CYC, 16'hFFFE);
    readCheck("cycles_fffe", A_CYC, 16'hFFFE);
    readCheck("cycles_ffff", A_CYC, 16'hFFFF);
    readCheck("cycles_wrap", A_CYC, 16'h0000);

`ifdef CPU_IO_UART_EN
    $display("[TB] single frame 0x55");
    startQ.delete();
    writeBus(A_TX, 16'h0055);
    expQ.push_back(8'h55);
    wCyc = cyc;
    readCheck("status_after_push", A_STAT, 16'h0000);
    readCheck("status_sending", A_STAT, 16'h0006);
    while (cyc < wCyc + 40) stepCycle();
    readCheck("status_last_stop_cycle", A_STAT, 16'h0006);
    readCheck("status_idle_after_frame", A_STAT, 16'h0002);
    checkOutput("frame55_drained", 16'(expQ.size()), 16'h0000);
    checkOutput("frame55_count", 16'(startQ.size()), 16'h0001);
    if (startQ.size() > 0) checkOutput("tx_latency", 16'(startQ[0] - wCyc), 16'h0001);

    $display("[TB] burst with overflow and full push/pop");
    startQ.delete();
    writeBus(A_TX, 16'h00C3);
    expQ.push_back(8'hC3);
    wCyc = cyc;
    stepCycle();
    stepCycle();
    for (int i = 0; i < 9; i++) begin
      writeBus(A_TX, 16'h0010 + 16'(i));
      if (i < 8) expQ.push_back(8'h10 + 8'(i));
    end
    readCheck("status_overflow", A_STAT, 16'h000D);
    writeBus(A_STAT, 16'h0008);
    readCheck("status_overflow_cleared", A_STAT, 16'h0005);
    while (cyc < wCyc + 40) stepCycle();
    writeBus(A_TX, 16'h00E7);
    expQ.push_back(8'hE7);
    readCheck("status_full_push_pop", A_STAT, 16'h0005);
    for (int i = 0; i < 600 && expQ.size() != 0; i++) stepCycle();
    repeat (4) stepCycle();
    checkOutput("burst_drained", 16'(expQ.size()), 16'h0000);
    checkOutput("burst_frames", 16'(startQ.size()), 16'h000A);
    for (int i = 1; i < startQ.size(); i++) begin
      checkOutput("frame_gap", 16'(startQ[i] - startQ[i-1]), 16'h0028);
    end
    readCheck("status_idle_after_burst", A_STAT, 16'h0002);

    $display("[TB] reset mid-frame");
    startQ.delete();
    writeBus(A_TX, 16'h0000);
    expQ.push_back(8'h00);
    wCyc = cyc;
    writeBus(A_TX, 16'h00FF);
    expQ.push_back(8'hFF);
    while (cyc < wCyc + 10) stepCycle();
    @(negedge clk);
    checkOutput("tx_low_mid_data", 16'(uart_tx), 16'h0000);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    startQ.delete();
    #1;
    checkOutput("tx_async_reset", 16'(uart_tx), 16'h0001);
    checkOutput("leds_async_reset", 16'(leds), 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    readCheck("status_after_reset", A_STAT, 16'h0002);
    repeat (60) stepCycle();
    checkOutput("no_frame_after_reset", 16'(startQ.size()), 16'h0000);
    checkOutput("tx_idle_after_reset", 16'(uart_tx), 16'h0001);
`else
    $display("[TB] UART disabled build");
    startQ.delete();
    writeBus(A_TX, 16'h0055);
    readCheck("status_no_uart", A_STAT, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      repeat (10) stepCycle();
      checkOutput("tx_stays_idle", 16'(uart_tx), 16'h0001);
    end
    checkOutput("no_frames", 16'(startQ.size()), 16'h0000);
    readCheck("txdata_read_no_uart", A_TX, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_io.md
# cpu_io

Memory/I-O bus slave directly downstream of the stack CPU core. It decodes every CPU word address:
- The low region goes through to an asynchronous-read RAM.
- The top 256 words form a memory-mapped register page: LED register, UART transmit FIFO with 8N1 serializer, status register and free-running cycle counter.

Reads are zero-latency so the core can fetch and load in the same cycle it drives the address. Writes commit on the clock edge where the CPU write strobe is high.

## Interface
Parameters:
- IO_BASE, 15'h7F00, word address of I/O page (low 8 bits must be 0)
- FIFO_DEPTH, 8, UART FIFO entries, power of two, 2..64
- BAUD_DIV, 434, clk cycles per UART bit (>=2)

Ports (one clock, `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_address  in  16  word address from CPU (bit 15 ignored; CPU drives it 0)
- cpu_wdata  in  16  store data
- cpu_wr  in  1  write strobe, one write per rising edge where high
- cpu_rdata  out  16  read data, combinational on cpu_address
- ram_addr  out  15  = cpu_address[14:0]
- ram_wdata  out  16  = cpu_wdata
- ram_we  out  1  cpu_wr when address is outside the I/O page, else 0
- ram_rdata  in  16  asynchronous RAM read data
- leds  out  8  LED register
- uart_tx  out  1  serial output, idle high

## Operation
- Decode: io_sel = (cpu_address[14:8] == IO_BASE[14:8]). If io_sel is low, cpu_rdata = ram_rdata; if it is high, cpu_rdata = register selected by cpu_address[7:0].
- I/O map (word offsets):
  - 0x00 LED: RW. Low 8 bits stored; reads {8'h00, leds}.
  - 0x01 TXDATA: write pushes cpu_wdata[7:0] into FIFO; reads 0.
  - 0x02 STATUS: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow (sticky), other bits 0. Writing with bit3=1 clears overflow; other bits are read-only.
  - 0x03 CYCLES: 16-bit counter, +1 every clk, wraps 0xFFFF->0x0000. A write loads cpu_wdata.
  - Other offsets read 0, writes ignored.
- FIFO: circular, read/write pointers one bit wider than the index.
  - A push when full is dropped and sets overflow.
  - A push and a pop in the same cycle while full: the pop is taken first, the push is accepted, and overflow is not set.
- Serializer FSM states:
  - IDLE: uart_tx=1. If FIFO is non-empty, pop it into the shift register, go to START.
  - START: uart_tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each.
  - STOP: uart_tx=1 for BAUD_DIV cycles. Then, if FIFO is non-empty, pop and go to START directly with no idle cycle; else go to IDLE.
- tx_busy = (state != IDLE).
- Baud counter: counts 0..BAUD_DIV-1 and is reset on every state entry.

## Timing
- Reset values: leds=0, uart_tx=1, FIFO empty, overflow=0, CYCLES=0, FSM=IDLE. ram_we and cpu_rdata follow their inputs combinationally.
- Reset mid-frame: uart_tx returns to 1 asynchronously and FIFO contents are discarded.
- Read latency: 0 cycles for RAM and registers.
- Register writes are visible to reads from the next cycle onward.
- CYCLES written at edge N reads the written value during cycle N+1, then increments.
- TX latency: TXDATA write at edge N with FIFO empty and FSM IDLE → pop at edge N+1 → uart_tx falls after edge N+1.
- Frame length: exactly 10*BAUD_DIV cycles. Back-to-back frames have no gap.
- fifo_empty clears the cycle after a push and sets the cycle after the last pop.

## Configuration
- CPU_IO_UART_EN defined: FIFO, serializer and overflow logic are present as described.
- CPU_IO_UART_EN undefined: that logic is removed.
  - uart_tx is tied to 1.
  - TXDATA writes are ignored.
  - STATUS reads 16'h0002 (empty only).
  - LED, CYCLES and RAM pass-through are unchanged.

## Test plan
- Reset, then read offsets 0x00–0x03 → 0x0000, 0x0000, 0x0002, then CYCLES counting up from 0; uart_tx=1.
- Write 0x1234 to word 0x0010 → ram_we=1 that cycle, ram_addr=0x0010. Write 0x00A5 to IO_BASE → leds=0xA5, ram_we=0, a read of IO_BASE returns 0x00A5.
- BAUD_DIV=4: write 0x55 to TXDATA → uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles), then IDLE, tx_busy=0.
- Write 9 bytes back-to-back with FIFO_DEPTH=8 while the serializer is busy → exactly one dropped, overflow=1. Write STATUS 0x0008 → overflow=0. The remaining bytes go out with no inter-frame gap.
- Write 0xFFFE to CYCLES → subsequent reads 0xFFFE, 0xFFFF, 0x0000.
- Assert rst_n low mid-DATA bit → uart_tx=1 immediately; STATUS reads 0x0002 after release.
